// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters; combinational lookup, update on clk.
// Optional macro BP_JALR_PREDICT_EN enables allocation and taken-prediction of jalr entries.
module branch_predictor #(
  parameter int unsigned ENTRIES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        predict_taken,
  output logic [31:0] predict_pc,
  output logic        is_conditional_branch,
  output logic        is_jal,
  output logic        is_jalr,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_is_conditional_branch,
  input  logic        upd_is_jal,
  input  logic        upd_is_jalr,
  input  logic        upd_br_taken,
  input  logic [31:0] upd_br_target
);

  localparam int unsigned IDX = $clog2(ENTRIES);
  localparam int unsigned TW  = 30 - IDX;

`ifdef BP_JALR_PREDICT_EN
  localparam bit JALR_EN = 1'b1;
`else
  localparam bit JALR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    BR_COND = 2'd0,
    BR_JAL  = 2'd1,
    BR_JALR = 2'd2
  } br_type_e;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TW-1:0]      tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  br_type_e           type_q   [ENTRIES];

  // Lookup path
  logic [IDX-1:0] lk_idx;
  logic [TW-1:0]  lk_tag;
  logic           lk_hit;

  assign lk_idx = if_pc[IDX+1:2];
  assign lk_tag = if_pc[31:IDX+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  always_comb begin
    predict_taken         = 1'b0;
    is_conditional_branch = 1'b0;
    is_jal                = 1'b0;
    is_jalr               = 1'b0;
    if (lk_hit) begin
      case (type_q[lk_idx])
        BR_COND: begin
          is_conditional_branch = 1'b1;
          predict_taken         = ctr_q[lk_idx][1];
        end
        BR_JAL: begin
          is_jal        = 1'b1;
          predict_taken = 1'b1;
        end
        BR_JALR: begin
          is_jalr       = JALR_EN;
          predict_taken = JALR_EN;
        end
        default: ;
      endcase
    end
    predict_pc = predict_taken ? target_q[lk_idx] : (if_pc + 32'd4);
  end

  // Update path
  logic [IDX-1:0] up_idx;
  logic [TW-1:0]  up_tag;
  br_type_e       up_type;
  logic           up_type_ok;
  logic           up_hit;
  logic           wr_en;
  logic [31:0]    wr_target;
  logic [1:0]     wr_ctr;

  assign up_idx = upd_pc[IDX+1:2];
  assign up_tag = upd_pc[31:IDX+2];

  always_comb begin
    up_type    = BR_COND;
    up_type_ok = 1'b0;
    if (upd_is_conditional_branch) begin
      up_type_ok = 1'b1;
    end else if (upd_is_jal) begin
      up_type    = BR_JAL;
      up_type_ok = 1'b1;
    end else if (upd_is_jalr && JALR_EN) begin
      up_type    = BR_JALR;
      up_type_ok = 1'b1;
    end
  end

  // A type mismatch on a tag hit counts as a miss, so it re-allocates when taken.
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag) && (type_q[up_idx] == up_type);

  always_comb begin
    wr_en     = 1'b0;
    wr_target = target_q[up_idx];
    wr_ctr    = ctr_q[up_idx];
    valid_d   = valid_q;
    if (upd_en && up_type_ok) begin
      if (up_hit) begin
        wr_en = 1'b1;
        if (upd_br_taken) wr_target = upd_br_target;
        if (up_type == BR_COND) begin
          if (upd_br_taken) begin
            if (ctr_q[up_idx] != 2'd3) wr_ctr = ctr_q[up_idx] + 2'd1;
          end else begin
            if (ctr_q[up_idx] != 2'd0) wr_ctr = ctr_q[up_idx] - 2'd1;
          end
        end else begin
          wr_ctr = 2'd3;
        end
      end else if (upd_br_taken) begin
        wr_en           = 1'b1;
        valid_d[up_idx] = 1'b1;
        wr_target       = upd_br_target;
        wr_ctr          = (up_type == BR_COND) ? 2'd2 : 2'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (wr_en) begin
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= wr_target;
        ctr_q[up_idx]    <= wr_ctr;
        type_q[up_idx]   <= up_type;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{upd_pc[1:0], upd_is_jalr};

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random traffic vs a table model.
module tb_branch_predictor;

  localparam int unsigned E = 32;
`ifdef BP_JALR_PREDICT_EN
  localparam bit JALR_EN = 1'b1;
`else
  localparam bit JALR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        predict_taken;
  logic [31:0] predict_pc;
  logic        is_conditional_branch, is_jal, is_jalr;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_is_conditional_branch, upd_is_jal, upd_is_jalr;
  logic        upd_br_taken;
  logic [31:0] upd_br_target;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(E)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .predict_taken(predict_taken), .predict_pc(predict_pc),
    .is_conditional_branch(is_conditional_branch), .is_jal(is_jal), .is_jalr(is_jalr),
    .upd_en(upd_en), .upd_pc(upd_pc),
    .upd_is_conditional_branch(upd_is_conditional_branch),
    .upd_is_jal(upd_is_jal), .upd_is_jalr(upd_is_jalr),
    .upd_br_taken(upd_br_taken), .upd_br_target(upd_br_target)
  );

  // Model table: type 0 = cond, 1 = jal, 2 = jalr
  bit          m_valid [E];
  int unsigned m_tag   [E];
  logic [31:0] m_tgt   [E];
  int          m_ctr   [E];
  int          m_typ   [E];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit r, input logic [31:0] pc, input bit ue, input logic [31:0] upc,
                       input logic [2:0] ty, input bit tk, input logic [31:0] tgt);
    rst = r; if_pc = pc; upd_en = ue; upd_pc = upc;
    upd_is_conditional_branch = ty[0]; upd_is_jal = ty[1]; upd_is_jalr = ty[2];
    upd_br_taken = tk; upd_br_target = tgt;
    #2;
  endtask

  task automatic model_check();
    int unsigned idx, tg;
    bit hit, tk;
    logic [31:0] npc;
    idx = (if_pc / 4) % E;
    tg  = if_pc / (4 * E);
    hit = m_valid[idx] && (m_tag[idx] == tg);
    tk  = hit && ((m_typ[idx] == 1) || (m_typ[idx] == 2 && JALR_EN) || (m_typ[idx] == 0 && m_ctr[idx] >= 2));
    npc = if_pc + 32'd4;
    if (tk) npc = m_tgt[idx];
    check("mdl_taken", {31'd0, predict_taken}, {31'd0, tk});
    check("mdl_pc", predict_pc, npc);
    check("mdl_cond", {31'd0, is_conditional_branch}, {31'd0, hit && m_typ[idx] == 0});
    check("mdl_jal", {31'd0, is_jal}, {31'd0, hit && m_typ[idx] == 1});
    check("mdl_jalr", {31'd0, is_jalr}, {31'd0, hit && m_typ[idx] == 2 && JALR_EN});
  endtask

  task automatic model_update();
    int unsigned idx, tg;
    int ty;
    idx = (upd_pc / 4) % E;
    tg  = upd_pc / (4 * E);
    if (rst) begin
      for (int i = 0; i < E; i++) m_valid[i] = 0;
      return;
    end
    if (!upd_en) return;
    if (upd_is_conditional_branch) ty = 0;
    else if (upd_is_jal) ty = 1;
    else if (upd_is_jalr && JALR_EN) ty = 2;
    else return;
    if (m_valid[idx] && m_tag[idx] == tg && m_typ[idx] == ty) begin
      if (upd_br_taken) m_tgt[idx] = upd_br_target;
      if (ty == 0) m_ctr[idx] = upd_br_taken ? ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3)
                                             : ((m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0);
      else m_ctr[idx] = 3;
    end else if (upd_br_taken) begin
      m_valid[idx] = 1; m_tag[idx] = tg; m_tgt[idx] = upd_br_target;
      m_typ[idx] = ty; m_ctr[idx] = (ty == 0) ? 2 : 3;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // One cycle: drive inputs, check against model, clock.
  task automatic cyc(input bit r, input logic [31:0] pc, input bit ue, input logic [31:0] upc,
                     input logic [2:0] ty, input bit tk, input logic [31:0] tgt);
    drive(r, pc, ue, upc, ty, tk, tgt);
    model_check();
    advance();
  endtask

  task automatic expect_pred(input string tag, input bit tk, input logic [31:0] pc, input logic [2:0] fl);
    check({tag, "_taken"}, {31'd0, predict_taken}, {31'd0, tk});
    check({tag, "_pc"}, predict_pc, pc);
    check({tag, "_flags"}, {29'd0, is_jalr, is_jal, is_conditional_branch}, {29'd0, fl});
  endtask

  initial begin
    logic [31:0] pc, upc, tgt;
    logic [2:0]  ty;
    int unsigned r;

    for (int i = 0; i < E; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = '0; m_ctr[i] = 0; m_typ[i] = 0;
    end
    drive(1'b1, 32'h100, 1'b0, '0, 3'b000, 1'b0, '0);
    @(negedge clk);

    // Reset held two cycles
    cyc(1'b1, 32'h100, 1'b0, '0, 3'b000, 1'b0, '0);
    drive(1'b1, 32'h100, 1'b0, '0, 3'b000, 1'b0, '0);
    expect_pred("rst", 1'b0, 32'h104, 3'b000);
    advance();
    drive(1'b0, 32'hFFFF_FFFC, 1'b0, '0, 3'b000, 1'b0, '0);
    expect_pred("wrap", 1'b0, 32'h0, 3'b000);
    model_check();
    advance();

    // Allocation of a taken conditional branch
    cyc(1'b0, 32'h100, 1'b1, 32'h40, 3'b001, 1'b1, 32'h200);
    drive(1'b0, 32'h40, 1'b0, '0, 3'b000, 1'b0, '0);
    expect_pred("alloc", 1'b1, 32'h200, 3'b001);
    advance();

    // Hysteresis: 2 -> 1 -> 0, then 1 (still not taken), then 2
    cyc(1'b0, 32'h40, 1'b1, 32'h40, 3'b001, 1'b0, 32'h0);
    cyc(1'b0, 32'h40, 1'b1, 32'h40, 3'b001, 1'b0, 32'h0);
    drive(1'b0, 32'h40, 1'b0, '0, 3'b000, 1'b0, '0);
    expect_pred("hyst0", 1'b0, 32'h44, 3'b001);
    advance();
    cyc(1'b0, 32'h40, 1'b1, 32'h40, 3'b001, 1'b1, 32'h200);
    drive(1'b0, 32'h40, 1'b0, '0, 3'b000, 1'b0, '0);
    expect_pred("hyst1", 1'b0, 32'h44, 3'b001);
    advance();
    cyc(1'b0, 32'h40, 1'b1, 32'h40, 3'b001, 1'b1, 32'h200);
    drive(1'b0, 32'h40, 1'b0, '0, 3'b000, 1'b0, '0);
    expect_pred("hyst2", 1'b1, 32'h200, 3'b001);
    advance();

    // Aliasing: 0x10 and 0x90 share an index
    cyc(1'b0, 32'h0, 1'b1, 32'h10, 3'b010, 1'b1, 32'h300);
    cyc(1'b0, 32'h10, 1'b1, 32'h90, 3'b010, 1'b1, 32'h400);
    drive(1'b0, 32'h10, 1'b0, '0, 3'b000, 1'b0, '0);
    expect_pred("alias_old", 1'b0, 32'h14, 3'b000);
    advance();
    drive(1'b0, 32'h90, 1'b0, '0, 3'b000, 1'b0, '0);
    expect_pred("alias_new", 1'b1, 32'h400, 3'b010);
    advance();

    // Same-cycle lookup and allocation: no bypass
    drive(1'b0, 32'h80, 1'b1, 32'h80, 3'b001, 1'b1, 32'h600);
    expect_pred("coll_now", 1'b0, 32'h84, 3'b000);
    model_check();
    advance();
    drive(1'b0, 32'h80, 1'b0, '0, 3'b000, 1'b0, '0);
    expect_pred("coll_next", 1'b1, 32'h600, 3'b001);
    advance();

    // jalr behaviour depends on the build option
    cyc(1'b0, 32'h0, 1'b1, 32'h20, 3'b100, 1'b1, 32'h500);
    drive(1'b0, 32'h20, 1'b0, '0, 3'b000, 1'b0, '0);
`ifdef BP_JALR_PREDICT_EN
    expect_pred("jalr", 1'b1, 32'h500, 3'b100);
`else
    expect_pred("jalr", 1'b0, 32'h24, 3'b000);
`endif
    advance();

    // Reset wins over a simultaneous update
    cyc(1'b1, 32'h60, 1'b1, 32'h60, 3'b010, 1'b1, 32'h700);
    drive(1'b0, 32'h60, 1'b0, '0, 3'b000, 1'b0, '0);
    expect_pred("rst_prio", 1'b0, 32'h64, 3'b000);
    advance();
    drive(1'b0, 32'h40, 1'b0, '0, 3'b000, 1'b0, '0);
    expect_pred("rst_clear", 1'b0, 32'h44, 3'b000);
    advance();

    // Random traffic over a small address pool to force hits and aliasing
    for (int n = 0; n < 2000; n++) begin
      upc = ($urandom_range(0, 2) * 4 * E) + ($urandom_range(0, 7) * 4);
      r = $urandom_range(0, 5);
      ty = (r == 1 || r == 4) ? 3'b001 : (r == 2) ? 3'b010 : (r == 3 || r == 5) ? 3'b100 : 3'b000;
      tgt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      r = $urandom_range(0, 39);
      if (r == 0) pc = 32'hFFFF_FFFC;
      else if (r < 14) pc = upc;
      else pc = ($urandom_range(0, 2) * 4 * E) + ($urandom_range(0, 7) * 4);
      cyc($urandom_range(0, 99) == 0, pc, $urandom_range(0, 3) != 0, upc, ty,
          $urandom_range(0, 2) != 0, tgt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
